req_upload_arbiter: RTL and testbench

- Shares the single request-FIFO upload path between the data-cache and instruction-cache request uploaders.
- Each uploader presents a flit stream: 16-bit flits, 2-bit ctrl (01 head, 10 body, 11 tail).
- The arbiter picks one uploader round-robin and locks the path to it until its tail flit is accepted. It forwards flits to the request FIFO and reports packet-protocol errors.

---
 rtl/req_upload_arbiter_if.sv | 36 +++
 rtl/req_upload_arbiter.sv | 109 ++++++++++
 tb/tb_req_upload_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/req_upload_arbiter_if.sv
// Flit-stream bundle between the two cache request uploaders, the arbiter and the request FIFO.
// The slave modport is the arbiter's view; the master modport is the uploader/FIFO side.
interface req_upload_arbiter_if #(
   parameter int FLIT_W = 16
) ();
   logic [FLIT_W-1:0] dc_flit_in;
   logic              v_dc_flit_in;
   logic [1:0]        dc_ctrl_in;
   logic              dc_flit_rdy;
   logic [FLIT_W-1:0] ic_flit_in;
   logic              v_ic_flit_in;
   logic [1:0]        ic_ctrl_in;
   logic              ic_flit_rdy;
   logic              req_fifo_rdy;
   logic [FLIT_W-1:0] flit_out;
   logic              v_flit_out;
   logic [1:0]        ctrl_out;
   logic [1:0]        arb_state;
   logic              pkt_err;

   modport slave (
      input  dc_flit_in, v_dc_flit_in, dc_ctrl_in,
      input  ic_flit_in, v_ic_flit_in, ic_ctrl_in,
      input  req_fifo_rdy,
      output dc_flit_rdy, ic_flit_rdy,
      output flit_out, v_flit_out, ctrl_out, arb_state, pkt_err
   );

   modport master (
      output dc_flit_in, v_dc_flit_in, dc_ctrl_in,
      output ic_flit_in, v_ic_flit_in, ic_ctrl_in,
      output req_fifo_rdy,
      input  dc_flit_rdy, ic_flit_rdy,
      input  flit_out, v_flit_out, ctrl_out, arb_state, pkt_err
   );
endinterface

// File: rtl/req_upload_arbiter.sv
// Round-robin arbiter sharing the request-FIFO upload path between the dcache and icache
// uploaders; the path stays locked to the winner until its tail flit is accepted.
//
// state   | meaning
// IDLE    | no grant; pick a winner from the registered priority, no flit moves
// BUSY_DC | path locked to the dcache uploader until tail or forced release
// BUSY_IC | path locked to the icache uploader until tail or forced release
module req_upload_arbiter #(
   parameter int FLIT_W        = 16,
   parameter int MAX_PKT_FLITS = 3
) (
   input logic                  clk,
   input logic                  rst,
   req_upload_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY_DC = 2'b01,
      BUSY_IC = 2'b10
   } state_e;

   localparam logic [1:0] CTRL_HEAD = 2'b01;
   localparam logic [1:0] CTRL_TAIL = 2'b11;
   localparam logic [3:0] CNT_LAST  = 4'(MAX_PKT_FLITS - 1);

   state_e            state_q, state_d;
   logic              prio_q, prio_d;          // 0: dcache holds priority, 1: icache
   logic [3:0]        flit_cnt_q, flit_cnt_d;
   logic              pkt_err_q, pkt_err_d;

   logic [FLIT_W-1:0] sel_flit;
   logic [1:0]        sel_ctrl;
   logic              sel_v;
   logic              xfer;

   always_comb begin
      sel_flit = '0;
      sel_ctrl = 2'b00;
      sel_v    = 1'b0;
      case (state_q)
         BUSY_DC: begin
            sel_flit = bus.dc_flit_in;
            sel_ctrl = bus.dc_ctrl_in;
            sel_v    = bus.v_dc_flit_in;
         end
         BUSY_IC: begin
            sel_flit = bus.ic_flit_in;
            sel_ctrl = bus.ic_ctrl_in;
            sel_v    = bus.v_ic_flit_in;
         end
         default: ;
      endcase
   end

   assign xfer            = sel_v && bus.req_fifo_rdy;
   assign bus.flit_out    = sel_flit;
   assign bus.ctrl_out    = sel_ctrl;
   assign bus.v_flit_out  = sel_v;
   assign bus.dc_flit_rdy = (state_q == BUSY_DC) && bus.req_fifo_rdy;
   assign bus.ic_flit_rdy = (state_q == BUSY_IC) && bus.req_fifo_rdy;
   assign bus.arb_state   = state_q;
   assign bus.pkt_err     = pkt_err_q;

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      flit_cnt_d = flit_cnt_q;
      pkt_err_d  = pkt_err_q;
      case (state_q)
         IDLE: begin
            if (bus.v_dc_flit_in && (!bus.v_ic_flit_in || !prio_q))
               state_d = BUSY_DC;
            else if (bus.v_ic_flit_in)
               state_d = BUSY_IC;
         end
         BUSY_DC, BUSY_IC: begin
            if (xfer) begin
               if (flit_cnt_q == 4'd0 && sel_ctrl != CTRL_HEAD)
                  pkt_err_d = 1'b1;
               // A tail always wins over the length limit, so an on-time tail is never flagged.
               if (sel_ctrl == CTRL_TAIL || flit_cnt_q == CNT_LAST) begin
                  if (sel_ctrl != CTRL_TAIL)
                     pkt_err_d = 1'b1;
                  state_d    = IDLE;
                  flit_cnt_d = 4'd0;
                  prio_d     = (state_q == BUSY_DC);
               end else begin
                  flit_cnt_d = flit_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         flit_cnt_q <= 4'd0;
         pkt_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         flit_cnt_q <= flit_cnt_d;
         pkt_err_q  <= pkt_err_d;
      end
   end
endmodule

// File: tb/tb_req_upload_arbiter.sv
// Directed bench for req_upload_arbiter: single packet, round-robin, stall, length limit,
// bad head, single-flit packet and asynchronous reset mid-packet.
module tb_req_upload_arbiter;
   localparam int FLIT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   req_upload_arbiter_if #(.FLIT_W(FLIT_W)) bus ();

   req_upload_arbiter #(.FLIT_W(FLIT_W), .MAX_PKT_FLITS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      bus.dc_flit_in   = '0;
      bus.v_dc_flit_in = 1'b0;
      bus.dc_ctrl_in   = 2'b00;
      bus.ic_flit_in   = '0;
      bus.v_ic_flit_in = 1'b0;
      bus.ic_ctrl_in   = 2'b00;
      bus.req_fifo_rdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clr_inputs();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clr_inputs();
      bus.v_dc_flit_in = 1'b1;
      bus.dc_ctrl_in   = 2'b01;
      bus.dc_flit_in   = 16'h1234;
      bus.req_fifo_rdy = 1'b1;
      tick();
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", bus.arb_state); end
      checks++; if (bus.v_flit_out !== 1'b0) begin errors++; $display("FAIL reset_vout: got %b expected 0", bus.v_flit_out); end
      checks++; if (bus.flit_out !== 16'h0) begin errors++; $display("FAIL reset_flit: got %h expected 0000", bus.flit_out); end
      checks++; if (bus.dc_flit_rdy !== 1'b0) begin errors++; $display("FAIL reset_dc_rdy: got %b expected 0", bus.dc_flit_rdy); end
      checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL reset_pkt_err: got %b expected 0", bus.pkt_err); end
      clr_inputs();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_dc();
      logic [15:0] fl [3] = '{16'hA000, 16'hA001, 16'hA002};
      logic [1:0]  ct [3] = '{2'b01, 2'b10, 2'b11};
      do_reset();
      bus.req_fifo_rdy = 1'b1;
      bus.v_dc_flit_in = 1'b1;
      bus.dc_flit_in   = fl[0];
      bus.dc_ctrl_in   = ct[0];
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL single_idle_state: got %b expected 00", bus.arb_state); end
      checks++; if (bus.v_flit_out !== 1'b0) begin errors++; $display("FAIL single_idle_vout: got %b expected 0", bus.v_flit_out); end
      checks++; if (bus.dc_flit_rdy !== 1'b0) begin errors++; $display("FAIL single_idle_rdy: got %b expected 0", bus.dc_flit_rdy); end
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.dc_flit_in = fl[i];
         bus.dc_ctrl_in = ct[i];
         #1;
         checks++; if (bus.arb_state !== 2'b01) begin errors++; $display("FAIL single_state[%0d]: got %b expected 01", i, bus.arb_state); end
         checks++; if (bus.flit_out !== fl[i]) begin errors++; $display("FAIL single_flit[%0d]: got %h expected %h", i, bus.flit_out, fl[i]); end
         checks++; if (bus.ctrl_out !== ct[i]) begin errors++; $display("FAIL single_ctrl[%0d]: got %b expected %b", i, bus.ctrl_out, ct[i]); end
         checks++; if (bus.dc_flit_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy[%0d]: got %b expected 1", i, bus.dc_flit_rdy); end
         checks++; if (bus.ic_flit_rdy !== 1'b0) begin errors++; $display("FAIL single_ic_rdy[%0d]: got %b expected 0", i, bus.ic_flit_rdy); end
      end
      tick();
      bus.v_dc_flit_in = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL single_end_state: got %b expected 00", bus.arb_state); end
      checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL single_pkt_err: got %b expected 0", bus.pkt_err); end
   endtask

   task automatic test_round_robin();
      logic [1:0] seq [3]      = '{2'b01, 2'b10, 2'b11};
      logic [1:0] exp_st [16]  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2,
                                   2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2};
      logic [1:0] exp_ct [16]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                   2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      int  dci = 0;
      int  ici = 0;
      logic dfire, ifire;
      do_reset();
      bus.req_fifo_rdy = 1'b1;
      for (int c = 0; c < 16; c++) begin
         bus.v_dc_flit_in = 1'b1;
         bus.dc_ctrl_in   = seq[dci % 3];
         bus.dc_flit_in   = 16'hD000 + 16'(dci);
         bus.v_ic_flit_in = 1'b1;
         bus.ic_ctrl_in   = seq[ici % 3];
         bus.ic_flit_in   = 16'hC000 + 16'(ici);
         @(negedge clk);
         checks++; if (bus.arb_state !== exp_st[c]) begin errors++; $display("FAIL rr_state[%0d]: got %b expected %b", c, bus.arb_state, exp_st[c]); end
         checks++; if (bus.ctrl_out !== exp_ct[c]) begin errors++; $display("FAIL rr_ctrl[%0d]: got %b expected %b", c, bus.ctrl_out, exp_ct[c]); end
         checks++; if (bus.ic_flit_rdy !== (exp_st[c] == 2'd2)) begin errors++; $display("FAIL rr_ic_rdy[%0d]: got %b in state %b", c, bus.ic_flit_rdy, exp_st[c]); end
         checks++; if (bus.dc_flit_rdy !== (exp_st[c] == 2'd1)) begin errors++; $display("FAIL rr_dc_rdy[%0d]: got %b in state %b", c, bus.dc_flit_rdy, exp_st[c]); end
         dfire = bus.dc_flit_rdy && bus.v_dc_flit_in;
         ifire = bus.ic_flit_rdy && bus.v_ic_flit_in;
         tick();
         if (dfire) dci++;
         if (ifire) ici++;
      end
      clr_inputs();
   endtask

   task automatic test_stall();
      do_reset();
      bus.req_fifo_rdy = 1'b1;
      bus.v_dc_flit_in = 1'b1;
      bus.dc_flit_in   = 16'hA000;
      bus.dc_ctrl_in   = 2'b01;
      tick();
      tick();
      bus.dc_flit_in   = 16'hA001;
      bus.dc_ctrl_in   = 2'b10;
      bus.req_fifo_rdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (bus.v_flit_out !== 1'b1) begin errors++; $display("FAIL stall_vout[%0d]: got %b expected 1", k, bus.v_flit_out); end
         checks++; if (bus.flit_out !== 16'hA001) begin errors++; $display("FAIL stall_flit[%0d]: got %h expected a001", k, bus.flit_out); end
         checks++; if (bus.dc_flit_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy[%0d]: got %b expected 0", k, bus.dc_flit_rdy); end
         checks++; if (dut.flit_cnt_q !== 4'd1) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d expected 1", k, dut.flit_cnt_q); end
         checks++; if (bus.arb_state !== 2'b01) begin errors++; $display("FAIL stall_state[%0d]: got %b expected 01", k, bus.arb_state); end
         tick();
      end
      bus.req_fifo_rdy = 1'b1;
      #1;
      checks++; if (bus.dc_flit_rdy !== 1'b1) begin errors++; $display("FAIL stall_resume_rdy: got %b expected 1", bus.dc_flit_rdy); end
      tick();
      bus.dc_flit_in = 16'hA002;
      bus.dc_ctrl_in = 2'b11;
      #1;
      checks++; if (dut.flit_cnt_q !== 4'd2) begin errors++; $display("FAIL stall_cnt_tail: got %0d expected 2", dut.flit_cnt_q); end
      tick();
      bus.v_dc_flit_in = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL stall_end_state: got %b expected 00", bus.arb_state); end
      checks++; if (dut.flit_cnt_q !== 4'd0) begin errors++; $display("FAIL stall_end_cnt: got %0d expected 0", dut.flit_cnt_q); end
      checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL stall_pkt_err: got %b expected 0", bus.pkt_err); end
   endtask

   task automatic test_max_len();
      logic [1:0] ct [3] = '{2'b01, 2'b10, 2'b10};
      do_reset();
      bus.req_fifo_rdy = 1'b1;
      bus.v_ic_flit_in = 1'b1;
      bus.ic_flit_in   = 16'hC000;
      bus.ic_ctrl_in   = ct[0];
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.ic_flit_in = 16'hC000 + 16'(i);
         bus.ic_ctrl_in = ct[i];
         #1;
         checks++; if (bus.arb_state !== 2'b10) begin errors++; $display("FAIL maxlen_state[%0d]: got %b expected 10", i, bus.arb_state); end
         checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL maxlen_early_err[%0d]: got %b expected 0", i, bus.pkt_err); end
      end
      tick();
      bus.v_ic_flit_in = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL maxlen_release: got %b expected 00", bus.arb_state); end
      checks++; if (bus.pkt_err !== 1'b1) begin errors++; $display("FAIL maxlen_err: got %b expected 1", bus.pkt_err); end
      bus.v_dc_flit_in = 1'b1;
      bus.dc_ctrl_in   = 2'b01;
      tick();
      tick();
      bus.dc_ctrl_in = 2'b10;
      tick();
      bus.dc_ctrl_in = 2'b11;
      tick();
      bus.v_dc_flit_in = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL maxlen_clean_state: got %b expected 00", bus.arb_state); end
      checks++; if (bus.pkt_err !== 1'b1) begin errors++; $display("FAIL maxlen_sticky: got %b expected 1", bus.pkt_err); end
   endtask

   task automatic test_bad_head();
      do_reset();
      bus.req_fifo_rdy = 1'b1;
      bus.v_dc_flit_in = 1'b1;
      bus.dc_flit_in   = 16'hB000;
      bus.dc_ctrl_in   = 2'b10;
      tick();
      #1;
      checks++; if (bus.flit_out !== 16'hB000) begin errors++; $display("FAIL badhead_flit: got %h expected b000", bus.flit_out); end
      checks++; if (bus.ctrl_out !== 2'b10) begin errors++; $display("FAIL badhead_ctrl: got %b expected 10", bus.ctrl_out); end
      checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL badhead_pre_err: got %b expected 0", bus.pkt_err); end
      tick();
      bus.dc_flit_in = 16'hB001;
      bus.dc_ctrl_in = 2'b11;
      #1;
      checks++; if (bus.pkt_err !== 1'b1) begin errors++; $display("FAIL badhead_err: got %b expected 1", bus.pkt_err); end
      tick();
      bus.v_dc_flit_in = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL badhead_end_state: got %b expected 00", bus.arb_state); end
   endtask

   task automatic test_single_flit();
      do_reset();
      bus.req_fifo_rdy = 1'b1;
      bus.v_dc_flit_in = 1'b1;
      bus.dc_flit_in   = 16'hE000;
      bus.dc_ctrl_in   = 2'b11;
      tick();
      #1;
      checks++; if (bus.arb_state !== 2'b01) begin errors++; $display("FAIL oneflit_state: got %b expected 01", bus.arb_state); end
      tick();
      bus.v_dc_flit_in = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL oneflit_done: got %b expected 00", bus.arb_state); end
      checks++; if (bus.pkt_err !== 1'b1) begin errors++; $display("FAIL oneflit_head_err: got %b expected 1", bus.pkt_err); end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      bus.req_fifo_rdy = 1'b1;
      bus.v_dc_flit_in = 1'b1;
      bus.dc_flit_in   = 16'hA000;
      bus.dc_ctrl_in   = 2'b01;
      tick();
      tick();
      bus.dc_flit_in = 16'hA001;
      bus.dc_ctrl_in = 2'b10;
      #1;
      checks++; if (bus.v_flit_out !== 1'b1) begin errors++; $display("FAIL midrst_pre_vout: got %b expected 1", bus.v_flit_out); end
      rst = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'b00) begin errors++; $display("FAIL midrst_state: got %b expected 00", bus.arb_state); end
      checks++; if (bus.v_flit_out !== 1'b0) begin errors++; $display("FAIL midrst_vout: got %b expected 0", bus.v_flit_out); end
      checks++; if (bus.flit_out !== 16'h0) begin errors++; $display("FAIL midrst_flit: got %h expected 0000", bus.flit_out); end
      checks++; if (bus.ctrl_out !== 2'b00) begin errors++; $display("FAIL midrst_ctrl: got %b expected 00", bus.ctrl_out); end
      checks++; if (bus.dc_flit_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b expected 0", bus.dc_flit_rdy); end
      #1;
      rst = 1'b1;
      bus.v_dc_flit_in = 1'b0;
      bus.v_ic_flit_in = 1'b1;
      bus.ic_flit_in   = 16'hC100;
      bus.ic_ctrl_in   = 2'b01;
      tick();
      #1;
      checks++; if (bus.arb_state !== 2'b10) begin errors++; $display("FAIL midrst_ic_grant: got %b expected 10", bus.arb_state); end
      checks++; if (bus.ic_flit_rdy !== 1'b1) begin errors++; $display("FAIL midrst_ic_rdy: got %b expected 1", bus.ic_flit_rdy); end
      clr_inputs();
   endtask

   initial begin
      clr_inputs();
      test_reset();
      test_single_dc();
      test_round_robin();
      test_stall();
      test_max_len();
      test_bad_head();
      test_single_flit();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
